// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU controller, the DMA engine, main memory and mem_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/memory side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_wait_;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_wait_,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_wait_,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the single main-memory port between the CPU and the DMA engine with
// fixed-latency accesses, round-robin tie-breaking and latched request data.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int MEM_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DMA  = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(MEM_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    logic              w_grant;
    logic              w_grant_dma;
    logic              w_last_access;
    logic              w_mem_en;
    logic              w_dma_ack;
    logic              w_cpu_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_dma   = 1'b0;
        w_last_access = 1'b0;
        w_mem_en      = 1'b0;
        w_dma_ack     = 1'b0;
        w_cpu_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    w_grant     = 1'b1;
                    w_grant_dma = bus.dma_req && (!bus.cpu_req || (r_last_grant == OWN_CPU));
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_mem_en = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_last_access = 1'b1;
                    w_state_nxt   = DONE;
                end
            end
            DONE: begin
                w_dma_ack   = (r_owner == OWN_DMA);
                w_cpu_done  = (r_owner == OWN_CPU);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_DMA;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_grant_dma;
                r_last_grant <= w_grant_dma;
                r_cnt        <= CNT_INIT;
                r_we         <= w_grant_dma ? bus.dma_we    : bus.cpu_we;
                r_addr       <= w_grant_dma ? bus.dma_addr  : bus.cpu_addr;
                r_wdata      <= w_grant_dma ? bus.dma_wdata : bus.cpu_wdata;
            end else if (w_mem_en && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Read data is valid only in the final access cycle.
            if (w_last_access && !r_we) begin
                if (r_owner == OWN_DMA) begin
                    r_dma_rdata <= bus.mem_rdata;
                end else begin
                    r_cpu_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_en && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dma_rdata = r_dma_rdata;
    assign bus.dma_ack   = w_dma_ack;
    // Active-low stall: held off during reset, otherwise low until the CPU's own DONE cycle.
    assign bus.cpu_wait_ = reset || !(bus.cpu_req && !w_cpu_done);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two instances (MEM_CYCLES=2 and 1), a memory model
// per instance and a queue of expected transactions checked as the bus produces them.
module tb_mem_bus_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    typedef struct packed {
        logic          own;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          sel;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    assign ifa.cpu_req   = cpu_req & ~sel;
    assign ifa.dma_req   = dma_req & ~sel;
    assign ifb.cpu_req   = cpu_req & sel;
    assign ifb.dma_req   = dma_req & sel;
    assign ifa.cpu_we    = cpu_we;
    assign ifb.cpu_we    = cpu_we;
    assign ifa.dma_we    = dma_we;
    assign ifb.dma_we    = dma_we;
    assign ifa.cpu_addr  = cpu_addr;
    assign ifb.cpu_addr  = cpu_addr;
    assign ifa.dma_addr  = dma_addr;
    assign ifb.dma_addr  = dma_addr;
    assign ifa.cpu_wdata = cpu_wdata;
    assign ifb.cpu_wdata = cpu_wdata;
    assign ifa.dma_wdata = dma_wdata;
    assign ifb.dma_wdata = dma_wdata;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        if (a == 12'h0A5) return 16'hBEEF;
        return {a, 4'h0} ^ 16'h5A3C;
    endfunction

    // Memory models: unwritten words read back a fixed address pattern.
    logic [DW-1:0] mema [0:4095];
    logic [DW-1:0] memb [0:4095];
    bit            wra  [0:4095];
    bit            wrb  [0:4095];
    always @(posedge clk) begin
        if (ifa.mem_en && ifa.mem_we) begin
            mema[ifa.mem_addr] <= ifa.mem_wdata;
            wra[ifa.mem_addr]  <= 1'b1;
        end
        if (ifb.mem_en && ifb.mem_we) begin
            memb[ifb.mem_addr] <= ifb.mem_wdata;
            wrb[ifb.mem_addr]  <= 1'b1;
        end
    end
    assign ifa.mem_rdata = wra[ifa.mem_addr] ? mema[ifa.mem_addr] : pat(ifa.mem_addr);
    assign ifb.mem_rdata = wrb[ifb.mem_addr] ? memb[ifb.mem_addr] : pat(ifb.mem_addr);

    logic          m_en, m_we, m_ack, m_wait;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_crd, m_drd;
    assign m_en    = sel ? ifb.mem_en    : ifa.mem_en;
    assign m_we    = sel ? ifb.mem_we    : ifa.mem_we;
    assign m_ack   = sel ? ifb.dma_ack   : ifa.dma_ack;
    assign m_wait  = sel ? ifb.cpu_wait_ : ifa.cpu_wait_;
    assign m_addr  = sel ? ifb.mem_addr  : ifa.mem_addr;
    assign m_wdata = sel ? ifb.mem_wdata : ifa.mem_wdata;
    assign m_crd   = sel ? ifb.cpu_rdata : ifa.cpu_rdata;
    assign m_drd   = sel ? ifb.dma_rdata : ifa.dma_rdata;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            en_cnt = 0;
    int            req_c;
    int            prev;
    bit            busy = 1'b0;
    txn_t          cur;
    txn_t          exp_q [$];
    txn_t          sw [5];
    logic [DW-1:0] exp_crd [2];
    logic [DW-1:0] exp_drd [2];
    bit            shw [0:4095];
    logic [DW-1:0] shv [0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic own, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        txn_t t;
        t.own  = own;
        t.we   = we;
        t.addr = a;
        t.wd   = wd;
        t.rd   = shw[a] ? shv[a] : pat(a);
        if (we) begin
            shv[a] = wd;
            shw[a] = 1'b1;
            t.rd   = '0;
        end
        exp_q.push_back(t);
    endtask

    // One clock: sample on the falling edge and check against the expected transaction.
    task automatic tick();
        int mc;
        @(negedge clk);
        cyc++;
        mc = sel ? 1 : 2;
        if (m_en) begin
            if (!busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", exp_q.size(), 1);
                    cur = '0;
                end else begin
                    cur = exp_q.pop_front();
                end
                busy   = 1'b1;
                en_cnt = 0;
            end
            en_cnt++;
            chk("mem_addr", 32'(m_addr), 32'(cur.addr));
            chk("mem_we", 32'(m_we), 32'(cur.we));
            if (cur.we) chk("mem_wdata", 32'(m_wdata), 32'(cur.wd));
            chk("ack_in_access", 32'(m_ack), 0);
            chk("wait_in_access", 32'(m_wait), 32'(!cpu_req));
        end else if (busy) begin
            busy = 1'b0;
            done_cnt++;
            done_cyc = cyc;
            chk("en_cycles", en_cnt, mc);
            chk("mem_we_done", 32'(m_we), 0);
            if (cur.own) begin
                chk("dma_ack", 32'(m_ack), 1);
                chk("wait_dma_done", 32'(m_wait), 32'(!cpu_req));
                if (!cur.we) exp_drd[sel] = cur.rd;
            end else begin
                chk("cpu_wait_done", 32'(m_wait), 1);
                chk("ack_cpu_done", 32'(m_ack), 0);
                if (!cur.we) exp_crd[sel] = cur.rd;
            end
            chk("cpu_rdata", 32'(m_crd), 32'(exp_crd[sel]));
            chk("dma_rdata", 32'(m_drd), 32'(exp_drd[sel]));
        end else begin
            chk("ack_idle", 32'(m_ack), 0);
            chk("mem_we_idle", 32'(m_we), 0);
            chk("wait_idle", 32'(m_wait), reset ? 32'd1 : 32'(!cpu_req));
        end
    endtask

    task automatic wait_done(input int n, input int max_cyc);
        int target;
        int k;
        target = done_cnt + n;
        k = 0;
        while (done_cnt < target && k < max_cyc) begin
            tick();
            k++;
        end
        if (done_cnt < target) chk("timeout", done_cnt, target);
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b1;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        dma_req = 1'b0;
        dma_we = 1'b0;
        dma_addr = '0;
        dma_wdata = '0;
        exp_crd[0] = '0; exp_crd[1] = '0;
        exp_drd[0] = '0; exp_drd[1] = '0;

        // Reset state, with cpu_req high to show cpu_wait_ forced high.
        tick();
        tick();
        chk("rst_mem_en", 32'(ifa.mem_en), 0);
        chk("rst_mem_addr", 32'(ifa.mem_addr), 0);
        chk("rst_mem_wdata", 32'(ifa.mem_wdata), 0);
        chk("rst_cpu_rdata", 32'(ifa.cpu_rdata), 0);
        chk("rst_dma_rdata", 32'(ifa.dma_rdata), 0);
        chk("rst_wait", 32'(ifa.cpu_wait_), 1);
        cpu_req = 1'b0;
        reset = 1'b0;
        tick();

        // Single CPU read of 0x0A5.
        cpu_addr = 12'h0A5;
        push(1'b0, 1'b0, 12'h0A5, '0);
        cpu_req = 1'b1;
        req_c = cyc;
        wait_done(1, 10);
        cpu_req = 1'b0;
        chk("cpu_rd_latency", done_cyc - req_c, 3);
        tick();

        // DMA write 0x1234 to 0x3FF, then CPU reads it back.
        dma_we = 1'b1;
        dma_addr = 12'h3FF;
        dma_wdata = 16'h1234;
        push(1'b1, 1'b1, 12'h3FF, 16'h1234);
        dma_req = 1'b1;
        req_c = cyc;
        wait_done(1, 10);
        dma_req = 1'b0;
        dma_we = 1'b0;
        chk("dma_wr_latency", done_cyc - req_c, 3);
        cpu_addr = 12'h3FF;
        push(1'b0, 1'b0, 12'h3FF, '0);
        cpu_req = 1'b1;
        wait_done(1, 10);
        cpu_req = 1'b0;
        tick();

        // DMA read at 0x100 with the request fields changed mid-access.
        dma_addr = 12'h100;
        push(1'b1, 1'b0, 12'h100, '0);
        dma_req = 1'b1;
        tick();
        dma_addr = 12'h001;
        dma_we = 1'b1;
        dma_wdata = 16'hFFFF;
        wait_done(1, 10);
        dma_req = 1'b0;
        dma_we = 1'b0;
        tick();

        // Both requesting from reset: CPU, DMA, CPU, DMA, four clocks apart.
        reset = 1'b1;
        exp_crd[0] = '0;
        exp_drd[0] = '0;
        tick();
        reset = 1'b0;
        cpu_addr = 12'h010;
        dma_addr = 12'h020;
        dma_we = 1'b1;
        dma_wdata = 16'h5555;
        push(1'b0, 1'b0, 12'h010, '0);
        push(1'b1, 1'b1, 12'h020, 16'h5555);
        push(1'b0, 1'b0, 12'h011, '0);
        push(1'b1, 1'b1, 12'h021, 16'h6666);
        cpu_req = 1'b1;
        dma_req = 1'b1;
        wait_done(1, 10);
        prev = done_cyc;
        cpu_addr = 12'h011;
        wait_done(1, 10);
        chk("rr_gap1", done_cyc - prev, 4);
        prev = done_cyc;
        dma_addr = 12'h021;
        dma_wdata = 16'h6666;
        wait_done(1, 10);
        chk("rr_gap2", done_cyc - prev, 4);
        prev = done_cyc;
        wait_done(1, 10);
        chk("rr_gap3", done_cyc - prev, 4);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        dma_we = 1'b0;
        tick();

        // Reset during the first ACCESS cycle of a CPU read.
        cpu_addr = 12'h0A5;
        push(1'b0, 1'b0, 12'h0A5, '0);
        cpu_req = 1'b1;
        tick();
        reset = 1'b1;
        cpu_req = 1'b0;
        busy = 1'b0;
        exp_crd[0] = '0;
        exp_drd[0] = '0;
        tick();
        chk("rstmid_mem_en", 32'(ifa.mem_en), 0);
        chk("rstmid_cpu_rdata", 32'(ifa.cpu_rdata), 0);
        chk("rstmid_ack", 32'(ifa.dma_ack), 0);
        chk("rstmid_mem_addr", 32'(ifa.mem_addr), 0);
        reset = 1'b0;
        tick();
        dma_addr = 12'h100;
        push(1'b0, 1'b0, 12'h0A5, '0);
        push(1'b1, 1'b0, 12'h100, '0);
        cpu_req = 1'b1;
        dma_req = 1'b1;
        wait_done(1, 10);
        cpu_req = 1'b0;
        wait_done(1, 10);
        dma_req = 1'b0;
        tick();

        // MEM_CYCLES=1 instance: single accesses, then a held tie.
        sel = 1'b1;
        tick();
        sw[0] = '{1'b0, 1'b0, 12'h0A5, 16'h0000, 16'h0000};
        sw[1] = '{1'b1, 1'b1, 12'h200, 16'hCAFE, 16'h0000};
        sw[2] = '{1'b1, 1'b0, 12'h200, 16'h0000, 16'h0000};
        sw[3] = '{1'b0, 1'b1, 12'h201, 16'h0F0F, 16'h0000};
        sw[4] = '{1'b0, 1'b0, 12'h201, 16'h0000, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            push(sw[i].own, sw[i].we, sw[i].addr, sw[i].wd);
            if (sw[i].own) begin
                dma_we = sw[i].we;
                dma_addr = sw[i].addr;
                dma_wdata = sw[i].wd;
                dma_req = 1'b1;
            end else begin
                cpu_we = sw[i].we;
                cpu_addr = sw[i].addr;
                cpu_wdata = sw[i].wd;
                cpu_req = 1'b1;
            end
            req_c = cyc;
            wait_done(1, 10);
            cpu_req = 1'b0;
            dma_req = 1'b0;
            chk("mc1_latency", done_cyc - req_c, 2);
            tick();
        end
        cpu_we = 1'b0;
        dma_we = 1'b0;
        cpu_addr = 12'h0A5;
        dma_addr = 12'h200;
        push(1'b1, 1'b0, 12'h200, '0);
        push(1'b0, 1'b0, 12'h0A5, '0);
        cpu_req = 1'b1;
        dma_req = 1'b1;
        wait_done(1, 10);
        prev = done_cyc;
        dma_req = 1'b0;
        wait_done(1, 10);
        chk("mc1_gap", done_cyc - prev, 3);
        cpu_req = 1'b0;
        tick();
        tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
